// File: rtl/ps2_rx_decoder_if.sv
// ps2_rx_decoder_if: PS/2 line inputs and decoded byte/key outputs of the host receiver.
interface ps2_rx_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       key_break;
  modport master (
    output ps2_clk, ps2_dat,
    input  byte_data, byte_valid, parity_err, frame_err, key_code, key_ext, key_make, key_break
  );
  modport slave (
    input  ps2_clk, ps2_dat,
    output byte_data, byte_valid, parity_err, frame_err, key_code, key_ext, key_make, key_break
  );
endinterface

// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder: deframes PS/2 device-to-host frames and folds E0/F0 prefixes into key events.
module ps2_rx_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic             CLOCK_50,
  input logic             Resetn,
  ps2_rx_decoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t          r_state, w_state;
  logic [2:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic [7:0]      r_shreg, w_shreg;
  logic [2:0]      r_bitcnt, w_bitcnt;
  logic            r_par, w_par;
  logic [TW-1:0]   r_tcnt, w_tcnt;
  logic            w_valid, w_perr, w_ferr;
  logic            w_fall, w_dat;
  logic [7:0]      r_byte_data, r_key_code;
  logic            r_byte_valid, r_parity_err, r_frame_err;
  logic            r_key_ext, r_key_make, r_key_break, r_ext_pend, r_brk_pend;
  logic            w_is_e0, w_is_f0, w_key_ev, w_err;
  // bit 0/1 form the synchronizer, bit 2 holds the previous synchronized level
  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_dat  = r_dat_sync[1];
  always_comb begin
    w_state  = r_state;
    w_shreg  = r_shreg;
    w_bitcnt = r_bitcnt;
    w_par    = r_par;
    w_tcnt   = (w_fall || r_state == IDLE) ? '0 : r_tcnt + 1'b1;
    w_valid  = 1'b0;
    w_perr   = 1'b0;
    w_ferr   = 1'b0;
    if (w_fall)
      case (r_state)
        IDLE: if (!w_dat) begin
          w_shreg  = '0;
          w_bitcnt = '0;
          w_state  = DATA;
        end
        DATA: begin
          w_shreg  = {w_dat, r_shreg[7:1]};
          w_bitcnt = r_bitcnt + 1'b1;
          w_state  = (r_bitcnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          w_par   = w_dat;
          w_state = STOP;
        end
        STOP: begin
          w_ferr  = !w_dat;
          w_perr  = w_dat && !(^{r_shreg, r_par});
          w_valid = w_dat && (^{r_shreg, r_par});
          w_state = IDLE;
        end
      endcase
    else if (r_state != IDLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      w_state = IDLE;
      w_ferr  = 1'b1;
      w_tcnt  = '0;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge Resetn)
    if (!Resetn) begin
      r_clk_sync   <= '1;
      r_dat_sync   <= '1;
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_par        <= 1'b0;
      r_tcnt       <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[1:0], bus.ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], bus.ps2_dat};
      r_state      <= w_state;
      r_shreg      <= w_shreg;
      r_bitcnt     <= w_bitcnt;
      r_par        <= w_par;
      r_tcnt       <= w_tcnt;
      r_byte_data  <= w_valid ? r_shreg : r_byte_data;
      r_byte_valid <= w_valid;
      r_parity_err <= w_perr;
      r_frame_err  <= w_ferr;
    end
  assign w_is_e0  = r_byte_valid && r_byte_data == 8'hE0;
  assign w_is_f0  = r_byte_valid && r_byte_data == 8'hF0;
  assign w_key_ev = r_byte_valid && !w_is_e0 && !w_is_f0;
  assign w_err    = r_parity_err | r_frame_err;
  always_ff @(posedge CLOCK_50 or negedge Resetn)
    if (!Resetn) begin
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_make  <= 1'b0;
      r_key_break <= 1'b0;
    end else begin
      r_ext_pend  <= (w_err || w_key_ev) ? 1'b0 : (w_is_e0 ? 1'b1 : r_ext_pend);
      r_brk_pend  <= (w_err || w_key_ev) ? 1'b0 : (w_is_f0 ? 1'b1 : r_brk_pend);
      r_key_make  <= w_key_ev && !r_brk_pend;
      r_key_break <= w_key_ev && r_brk_pend;
      r_key_code  <= w_key_ev ? r_byte_data : r_key_code;
      r_key_ext   <= w_key_ev ? r_ext_pend : r_key_ext;
    end
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_valid = r_byte_valid;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
  assign bus.key_code   = r_key_code;
  assign bus.key_ext    = r_key_ext;
  assign bus.key_make   = r_key_make;
  assign bus.key_break  = r_key_break;
endmodule

// File: doc/ps2_rx_decoder.md
# ps2_rx_decoder

Host-side PS/2 receiver that sits directly downstream of the PS/2 keyboard model and consumes its `ps2_clk` / `ps2_dat` lines. It synchronizes both lines into the `CLOCK_50` domain, deframes 11-bit device-to-host frames, checks odd parity and the stop bit, and emits raw bytes. It then folds the E0/F0 prefixes into key make/break events for the demo logic (HEX/LEDR display).

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 50000: idle-edge limit inside a frame (1 ms at 50 MHz); reduced in simulation.

Ports:
- `CLOCK_50`  in  1  system clock; all state updates on its rising edge.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  PS/2 clock from the device; asynchronous to `CLOCK_50`.
- `ps2_dat`  in  1  PS/2 data from the device.
- `byte_data`  out  8  last good byte; holds its value until the next good byte.
- `byte_valid`  out  1  one-cycle pulse when a good frame completes.
- `parity_err`  out  1  one-cycle pulse on a parity failure.
- `frame_err`  out  1  one-cycle pulse on a stop-bit failure or a timeout.
- `key_code`  out  8  scan code of the last key event; held between events.
- `key_ext`  out  1  the last key event was E0-prefixed; held.
- `key_make`  out  1  one-cycle pulse for a press event.
- `key_break`  out  1  one-cycle pulse for a release event.

## Operation

Reset:
- Sync flops go to 1 (line idle).
- FSM goes to IDLE.
- Shift register, bit counter, timeout counter and prefix flags go to 0.
- All outputs go to 0.

Input synchronization and sampling:
- Each line has a 2-flop synchronizer.
- A falling edge is `clk_prev & ~clk_sync`, where `clk_prev` is a third flop.
- `ps2_dat` is sampled from its synchronizer output in the same cycle as the edge.

FSM (advances only on a falling edge, except for timeout):
- IDLE:
  - Edge with data = 0 (start bit): clear the shift register, set bit count to 0, go to DATA.
  - Edge with data = 1: ignored, no error, stay in IDLE.
- DATA:
  - Shift the bit in LSB-first (`shreg <= {dat, shreg[7:1]}`).
  - After the 8th bit, go to PARITY.
- PARITY: capture the bit, go to STOP.
- STOP:
  - If the stop bit = 0: pulse `frame_err`.
  - Else if `^{shreg, parity} != 1`: pulse `parity_err`.
  - Else: load `byte_data` and pulse `byte_valid`.
  - In all three cases, return to IDLE.
- Timeout:
  - The counter clears on every edge and counts while not in IDLE.
  - When it reaches `TIMEOUT_CYCLES-1`: go to IDLE and pulse `frame_err`.
  - An edge in the same cycle wins; no timeout fires.

Key decoder (acts on `byte_valid`):
- Byte E0: set `ext_pend`; no key event.
- Byte F0: set `brk_pend`; no key event.
- Any other byte:
  - Load `key_code`, and set `key_ext = ext_pend`.
  - Pulse `key_break` if `brk_pend`, else pulse `key_make`.
  - Clear both pending flags.
- Any `parity_err` or `frame_err` clears both pending flags.
- `key_make` and `key_break` are never high together.
- Error pulses are mutually exclusive with `byte_valid`.

## Timing

Latency:
- The pin edge is first captured by sync flop 1 at rising edge k.
- The edge is detected combinationally after rising edge k+1.
- The FSM registers the edge at k+2. For the stop bit, this means `byte_valid`, `parity_err` and `frame_err` are high for exactly the cycle following k+2.
- `key_make` / `key_break` pulse one cycle after `byte_valid`; `key_code` and `key_ext` update in the same cycle as the pulse.

Input constraint:
- PS/2 clock half-period ≥ 4 `CLOCK_50` cycles.
- Data is stable from before the falling edge until after it.

Frames:
- Back-to-back frames are accepted with no dead cycles; IDLE accepts a start bit on the edge immediately after STOP.

Reset asserted mid-frame:
- All state clears immediately (asynchronously); the partial frame is discarded with no pulses.
- The first start bit after release is received normally.

## Test plan

- Frame 0x1B (data LSB-first 1,1,0,1,1,0,0,0; parity 1; stop 1) -> one `byte_valid` with `byte_data`=0x1B. Next cycle: `key_make`=1, `key_code`=0x1B, `key_ext`=0.
- Frames F0, then 1B -> two `byte_valid` pulses, no event after F0. One `key_break` with `key_code`=0x1B; `key_make` never pulses.
- Frames E0, F0, 75 -> single `key_break`, `key_code`=0x75, `key_ext`=1. Then frame 75 -> `key_make`, `key_ext`=0.
- Frame 0x1B with parity 0 -> `parity_err` pulse, no `byte_valid`. Sequence F0 + bad frame + 1B -> `key_make` (prefix cleared).
- Start bit plus 5 data bits, then the clock stalls -> `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last edge. Next frame 0x1C is decoded correctly. Stop bit = 0 -> `frame_err`, no `byte_valid`.
- `Resetn` pulsed low after 4 data bits -> all outputs 0 immediately, no pulses. Subsequent frame 0x1B -> `byte_valid` with 0x1B.
